fir_coeff_loader: RTL

Upstream control stage for the FIR filter cores (direct and transposed forms). It accepts a stream of NUM_TAPS signed coefficients over a valid/ready handshake and drives the filter's coefficient SRAM port: CoeffiUpdateFlag, CsnRam, WrnRam, AddrRam and WrDtRam. After the write sweep it runs one read sweep so the filter latches the new tap set. It then reports done, or reports an error if the coefficient stream stalls.

---
 rtl/fir_pkg.sv | 11 +
 rtl/fir_coeff_loader_if.sv | 22 ++
 rtl/fir_loader_timeout.sv | 20 ++
 rtl/fir_coeff_loader.sv | 91 +++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: constants and state encoding shared by the FIR cores and the coefficient loader
package fir_pkg;
  localparam int NUM_TAPS = 33;
  localparam int COEF_W = 16;
  localparam int ADDR_W = 6;
  localparam int LOAD_TIMEOUT = 255;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} loadStateT;
  function automatic int cntWidth(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/fir_coeff_loader_if.sv
// fir_coeff_loader_if: coefficient stream handshake plus the filter coefficient RAM port
interface fir_coeff_loader_if #(
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int ADDR_W = fir_pkg::ADDR_W
);
  logic coefValid;
  logic signed [COEF_W-1:0] coefData;
  logic coefReady;
  logic coeffiUpdateFlag;
  logic csnRam;
  logic wrnRam;
  logic [ADDR_W-1:0] addrRam;
  logic signed [COEF_W-1:0] wrDtRam;
  modport master (
    output coefValid, coefData,
    input coefReady, coeffiUpdateFlag, csnRam, wrnRam, addrRam, wrDtRam
  );
  modport slave (
    input coefValid, coefData,
    output coefReady, coeffiUpdateFlag, csnRam, wrnRam, addrRam, wrDtRam
  );
endinterface

// File: rtl/fir_loader_timeout.sv
// fir_loader_timeout: idle-cycle counter whose terminal flag marks the increment that reaches LIMIT
module fir_loader_timeout #(
  parameter int LIMIT = 255,
  parameter int W = $clog2(LIMIT + 1)
) (
  input logic iClk_12M,
  input logic iRst,
  input logic clear,
  input logic inc,
  output logic tc
);
  logic [W-1:0] count;
  assign tc = inc && count == W'(LIMIT - 1);
  // clear wins over inc so an accepted beat always restarts the idle window
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) count <= '0;
    else if (clear) count <= '0;
    else if (inc) count <= count + 1'b1;
  end
endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams NUM_TAPS coefficients into the filter RAM, then read-sweeps them once
module fir_coeff_loader #(
  parameter int NUM_TAPS = fir_pkg::NUM_TAPS,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int ADDR_W = fir_pkg::ADDR_W,
  parameter int TIMEOUT = fir_pkg::LOAD_TIMEOUT
) (
  input logic iClk_12M,
  input logic iRst,
  input logic iStart,
  fir_coeff_loader_if.slave coefBus,
  output logic oBusy,
  output logic oDone,
  output logic oErr
);
  import fir_pkg::*;
  localparam int CNT_W = cntWidth(NUM_TAPS, TIMEOUT);
  loadStateT state;
  logic [CNT_W-1:0] beatCnt;
  logic accept;
  logic stall;
  assign accept = coefBus.coefValid && coefBus.coefReady;
  fir_loader_timeout #(.LIMIT(TIMEOUT), .W(CNT_W)) idleTimer (
    .iClk_12M(iClk_12M),
    .iRst(iRst),
    .clear(state != WRITE || accept),
    .inc(!accept),
    .tc(stall)
  );
  // load sequencer; every RAM-port and status output is a register updated here
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
      beatCnt <= '0;
      coefBus.coefReady <= 1'b0;
      coefBus.coeffiUpdateFlag <= 1'b0;
      coefBus.csnRam <= 1'b1;
      coefBus.wrnRam <= 1'b1;
      coefBus.addrRam <= '0;
      coefBus.wrDtRam <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oErr <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: if (iStart) begin
          state <= WRITE;
          beatCnt <= '0;
          oErr <= 1'b0;
          oBusy <= 1'b1;
          coefBus.coefReady <= 1'b1;
          coefBus.coeffiUpdateFlag <= 1'b1;
        end
        WRITE: if (beatCnt == CNT_W'(NUM_TAPS)) begin
          state <= READ;
          coefBus.coeffiUpdateFlag <= 1'b0;
          coefBus.csnRam <= 1'b0;
          coefBus.wrnRam <= 1'b1;
          coefBus.addrRam <= ADDR_W'(1);
        end else if (stall) begin
          state <= IDLE;
          oErr <= 1'b1;
          oBusy <= 1'b0;
          coefBus.coefReady <= 1'b0;
          coefBus.coeffiUpdateFlag <= 1'b0;
          coefBus.csnRam <= 1'b1;
          coefBus.wrnRam <= 1'b1;
          coefBus.addrRam <= '0;
        end else begin
          coefBus.csnRam <= !accept;
          coefBus.wrnRam <= !accept;
          if (accept) begin
            coefBus.addrRam <= ADDR_W'(beatCnt + 1'b1);
            coefBus.wrDtRam <= COEF_W'(coefBus.coefData);
            beatCnt <= beatCnt + 1'b1;
            coefBus.coefReady <= beatCnt != CNT_W'(NUM_TAPS - 1);
          end
        end
        READ: if (coefBus.addrRam == ADDR_W'(NUM_TAPS)) begin
          state <= DONE;
          oDone <= 1'b1;
          oBusy <= 1'b0;
          coefBus.csnRam <= 1'b1;
          coefBus.addrRam <= '0;
        end else coefBus.addrRam <= coefBus.addrRam + 1'b1;
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
